flash_sample_sequencer: RTL and testbench
=========================================

// Module: flash_sample_sequencer
// PURPOSE
//  Parametrised successor to the single-direction flash audio address counter. Fetches WORD_W-bit
//  flash words over a req/valid handshake, emits them as SAMPLE_W-bit samples, one per sample_tick.
//  Adds reverse playback, optional looping, restart, underrun flag and done pulse.
//  Sits between the keyboard/PicoBlaze control logic and the flash read master; feeds the audio codec path.
// PARAMETERS
//  ADDR_W    23  flash word-address width
//  WORD_W    32  flash data width; must be an integer multiple of SAMPLE_W
//  SAMPLE_W   8  audio sample width; LANES = WORD_W/SAMPLE_W (derived localparam)
// PORTS
//  clk          in   1         system clock (50 MHz); all logic rising-edge
//  reset_n      in   1         asynchronous, active-low reset
//  sample_tick  in   1         1-cycle strobe at the audio sample rate (e.g. 22 kHz)
//  play         in   1         1 = run, 0 = pause
//  dir          in   1         1 = forward (up), 0 = reverse (down)
//  loop_en      in   1         1 = wrap at range end, 0 = stop
//  silent       in   1         consume samples but output zero
//  restart      in   1         1-cycle pulse: abort and reload from range start
//  start_addr   in   ADDR_W    first word address of clip (inclusive)
//  end_addr     in   ADDR_W    last word address of clip (inclusive)
//  rd_req       out  1         flash read request
//  rd_addr      out  ADDR_W    flash word address, stable while rd_req=1
//  rd_valid     in   1         flash data valid; completes request
//  rd_data      in   WORD_W    flash word
//  audio_out    out  SAMPLE_W  current sample
//  sample_valid out  1         1-cycle pulse when audio_out updates
//  underrun     out  1         1-cycle pulse: sample_tick arrived with no word buffered
//  done         out  1         1-cycle pulse: clip finished (loop_en=0)
//  busy         out  1         1 in any state but IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rd_req=0, rd_addr=0, audio_out=0, sample_valid=0, underrun=0, done=0, busy=0, lane=0.
//  States: IDLE -> FETCH -> PLAY -> NEXT -> (FETCH | IDLE).
//  IDLE: when play=1 and start_addr<=end_addr: rd_addr = dir ? start_addr : end_addr; go FETCH.
//    start_addr>end_addr: remain IDLE, no request issued.
//  FETCH: rd_req=1 with rd_addr held. On the cycle rd_valid=1: latch rd_data, drop rd_req next cycle,
//    capture dir for this word, lane = dir ? 0 : LANES-1, go PLAY.
//  PLAY: each sample_tick with play=1: audio_out <= silent ? 0 : word[lane*SAMPLE_W +: SAMPLE_W],
//    sample_valid=1 the cycle after the tick. Lane steps +1 (fwd) / -1 (rev). After the last lane, go NEXT.
//  NEXT (1 cycle): end reached if (fwd && rd_addr==end_addr) || (rev && rd_addr==start_addr).
//    Not at end: rd_addr +/-1, go FETCH. At end with loop_en=1: reload (fwd start / rev end), go FETCH.
//    At end with loop_en=0: done=1 for one cycle, audio_out=0, go IDLE.
//  Pause (play=0): state, lane, rd_addr frozen; audio_out forced 0; ticks ignored (no underrun).
//    An outstanding FETCH still completes so the handshake is never broken.
//  dir sampled only at word latch; mid-word changes take effect at the next word.
//  sample_tick during FETCH with play=1: underrun=1, audio_out unchanged, no sample_valid.
//  restart (priority over all except reset): rd_req drops the same edge, lane cleared, rd_addr reloaded
//    per dir, go FETCH (IDLE if range invalid). Any late rd_valid from the aborted request is ignored
//    for one cycle after restart.
//  Reset asserted mid-fetch: all outputs return to reset values immediately (async).
//  Address arithmetic wraps modulo 2^ADDR_W, reached only if the range touches 0 or max.
// TESTING
//  1 fwd, start=0x10, end=0x11, data 0x44332211/0x88776655, 8 ticks -> 11,22,...,88; done pulse; IDLE.
//  2 rev, same range -> 88,77,...,11; rd_addr 0x11 then 0x10; done after 8th sample.
//  3 loop_en=1, start=end=0x20, word 0xDDCCBBAA, 12 ticks -> AA,BB,CC,DD x3; no done; rd_req every 4.
//  4 play=0 after 2nd sample, 5 ticks, play=1 -> audio_out=0 while paused; resumes at 3rd byte; no underrun.
//  5 rd_valid delayed 3 ticks -> 3 underrun pulses, audio_out holds; silent=1 -> samples read as 0x00.
//  6 restart pulsed while rd_req=1 at addr 0x15 -> rd_req drops, rd_addr=start; start>end -> stays IDLE.

Source files
------------

// File: rtl/flash_sample_sequencer.sv
// Flash-backed audio sample sequencer: fetches wide flash words and plays them out one sample
// per sample_tick, forward or reverse, with optional looping, restart, underrun and done pulses.
module flash_sample_sequencer #(
    parameter int unsigned ADDR_W   = 23,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_tick,
    input  logic                play,
    input  logic                dir,
    input  logic                loop_en,
    input  logic                silent,
    input  logic                restart,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_valid,
    input  logic [WORD_W-1:0]   rd_data,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                sample_valid,
    output logic                underrun,
    output logic                done,
    output logic                busy
);

    localparam int unsigned LANES  = WORD_W / SAMPLE_W;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StPlay, StNext} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                wdir_q, wdir_d;
    logic [SAMPLE_W-1:0] audio_q, audio_d;
    logic                sv_q, sv_d;
    logic                und_q, und_d;
    logic                done_q, done_d;
    logic                ign_q, ign_d;

    logic              range_ok;
    logic [ADDR_W-1:0] reload_addr;
    logic              at_end;
    logic              last_lane;

    assign range_ok    = (start_addr <= end_addr);
    assign reload_addr = dir ? start_addr : end_addr;
    // Word-level decisions use the direction captured with the word, not the live input.
    assign at_end      = wdir_q ? (addr_q == end_addr) : (addr_q == start_addr);
    assign last_lane   = wdir_q ? (lane_q == LAST_LANE) : (lane_q == '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        lane_d  = lane_q;
        wdir_d  = wdir_q;
        audio_d = audio_q;
        sv_d    = 1'b0;
        und_d   = 1'b0;
        done_d  = 1'b0;
        ign_d   = 1'b0;

        if (restart) begin
            lane_d  = '0;
            addr_d  = reload_addr;
            ign_d   = 1'b1;
            state_d = range_ok ? StFetch : StIdle;
        end else begin
            if (!play) begin
                audio_d = '0;
            end
            unique case (state_q)
                StIdle: begin
                    if (play && range_ok) begin
                        addr_d  = reload_addr;
                        lane_d  = '0;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    // Fetch proceeds even while paused so the flash handshake always completes.
                    if (rd_valid && !ign_q) begin
                        word_d  = rd_data;
                        wdir_d  = dir;
                        lane_d  = dir ? '0 : LAST_LANE;
                        state_d = StPlay;
                    end
                    if (sample_tick && play) begin
                        und_d = 1'b1;
                    end
                end
                StPlay: begin
                    if (sample_tick && play) begin
                        audio_d = silent ? '0 : word_q[lane_q*SAMPLE_W +: SAMPLE_W];
                        sv_d    = 1'b1;
                        if (last_lane) begin
                            state_d = StNext;
                        end else begin
                            lane_d = wdir_q ? lane_q + 1'b1 : lane_q - 1'b1;
                        end
                    end
                end
                StNext: begin
                    if (play) begin
                        if (sample_tick) begin
                            und_d = 1'b1;
                        end
                        if (!at_end) begin
                            addr_d  = wdir_q ? addr_q + 1'b1 : addr_q - 1'b1;
                            state_d = StFetch;
                        end else if (loop_en) begin
                            addr_d  = wdir_q ? start_addr : end_addr;
                            state_d = StFetch;
                        end else begin
                            done_d  = 1'b1;
                            audio_d = '0;
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            word_q  <= '0;
            lane_q  <= '0;
            wdir_q  <= 1'b1;
            audio_q <= '0;
            sv_q    <= 1'b0;
            und_q   <= 1'b0;
            done_q  <= 1'b0;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            wdir_q  <= wdir_d;
            audio_q <= audio_d;
            sv_q    <= sv_d;
            und_q   <= und_d;
            done_q  <= done_d;
            ign_q   <= ign_d;
        end
    end

    // Request is held off for the cycle after restart so a stale rd_valid cannot complete it.
    assign rd_req       = (state_q == StFetch) && !ign_q;
    assign rd_addr      = addr_q;
    assign audio_out    = play ? audio_q : '0;
    assign sample_valid = sv_q;
    assign underrun     = und_q;
    assign done         = done_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Self-checking bench for flash_sample_sequencer: flash responder model plus a sample scoreboard.
module tb_flash_sample_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        play = 1'b0;
    logic        dir = 1'b1;
    logic        loop_en = 1'b0;
    logic        silent = 1'b0;
    logic        restart = 1'b0;
    logic [22:0] start_addr = '0;
    logic [22:0] end_addr = '0;
    logic        rd_req;
    logic [22:0] rd_addr;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_data = '0;
    logic [7:0]  audio_out;
    logic        sample_valid;
    logic        underrun;
    logic        done;
    logic        busy;

    flash_sample_sequencer #(
        .ADDR_W  (23),
        .WORD_W  (32),
        .SAMPLE_W(8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .play        (play),
        .dir         (dir),
        .loop_en     (loop_en),
        .silent      (silent),
        .restart     (restart),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .audio_out   (audio_out),
        .sample_valid(sample_valid),
        .underrun    (underrun),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          undr_cnt = 0;
    int          done_cnt = 0;
    logic        flash_hold = 1'b0;
    logic [7:0]  exp_q[$];
    logic [22:0] fetch_log[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [22:0] a);
        case (a)
            23'h10:  return 32'h44332211;
            23'h11:  return 32'h88776655;
            23'h20:  return 32'hDDCCBBAA;
            default: return {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
        endcase
    endfunction

    // Expected sample order for one word, byte 0 first when playing forward.
    task automatic push_word(input logic [22:0] a, input bit fwd, input bit sil);
        logic [31:0] w;
        w = mem_word(a);
        for (int i = 0; i < 4; i++) begin
            int l;
            l = fwd ? i : 3 - i;
            exp_q.push_back(sil ? 8'h00 : w[l*8 +: 8]);
        end
    endtask

    // Flash responder: answers one cycle after seeing a request unless held.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                rd_valid = 1'b0;
            end else if (rd_req && !flash_hold && reset_n) begin
                rd_valid = 1'b1;
                rd_data  = mem_word(rd_addr);
                fetch_log.push_back(rd_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (sample_valid) begin
                check_val("sample_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_val("sample", {24'h0, audio_out}, {24'h0, exp_q.pop_front()});
                end
            end
            if (underrun) undr_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; sample_tick = 1'b0; restart = 1'b0; play = 1'b0;
        silent = 1'b0; loop_en = 1'b0; flash_hold = 1'b0; dir = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        fetch_log.delete();
        undr_cnt = 0;
        done_cnt = 0;
    endtask

    // With last set, play drops on the cycle the DUT returns to IDLE so it does not replay.
    task automatic tick(input bit last);
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        if (last) begin
            @(negedge clk);
            play = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic start_play(input logic [22:0] s, input logic [22:0] e, input bit d);
        start_addr = s; end_addr = e; dir = d; play = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_req(input int max);
        int n;
        n = 0;
        while (!rd_req && n < max) begin
            @(negedge clk);
            n++;
        end
        check_val("req_seen", {31'h0, rd_req}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: forward two-word clip, done pulse, back to idle
        do_reset();
        check_val("rst_req", {31'h0, rd_req}, 32'd0);
        check_val("rst_addr", {9'h0, rd_addr}, 32'd0);
        check_val("rst_audio", {24'h0, audio_out}, 32'd0);
        check_val("rst_busy", {31'h0, busy}, 32'd0);
        check_val("rst_sv", {31'h0, sample_valid}, 32'd0);
        start_play(23'h10, 23'h11, 1'b1);
        push_word(23'h10, 1'b1, 1'b0);
        push_word(23'h11, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(i == 7);
        check_val("t1_done", done_cnt, 1);
        check_val("t1_busy", {31'h0, busy}, 32'd0);
        check_val("t1_audio", {24'h0, audio_out}, 32'd0);
        check_val("t1_nfetch", fetch_log.size(), 2);
        check_val("t1_left", exp_q.size(), 0);
        check_val("t1_undr", undr_cnt, 0);

        // 2: reverse, same range
        do_reset();
        start_play(23'h10, 23'h11, 1'b0);
        push_word(23'h11, 1'b0, 1'b0);
        push_word(23'h10, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(i == 7);
        check_val("t2_nfetch", fetch_log.size(), 2);
        if (fetch_log.size() == 2) begin
            check_val("t2_addr0", {9'h0, fetch_log[0]}, 32'h11);
            check_val("t2_addr1", {9'h0, fetch_log[1]}, 32'h10);
        end
        check_val("t2_done", done_cnt, 1);
        check_val("t2_left", exp_q.size(), 0);

        // 3: looping single word
        do_reset();
        loop_en = 1'b1;
        start_play(23'h20, 23'h20, 1'b1);
        for (int k = 0; k < 3; k++) push_word(23'h20, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) tick(i == 11);
        check_val("t3_done", done_cnt, 0);
        check_val("t3_nfetch", fetch_log.size(), 4);
        foreach (fetch_log[i]) check_val("t3_addr", {9'h0, fetch_log[i]}, 32'h20);
        check_val("t3_busy", {31'h0, busy}, 32'd1);
        check_val("t3_left", exp_q.size(), 0);

        // 4: pause mid-word
        do_reset();
        start_play(23'h10, 23'h11, 1'b1);
        push_word(23'h10, 1'b1, 1'b0);
        push_word(23'h11, 1'b1, 1'b0);
        tick(0);
        tick(0);
        play = 1'b0;
        @(negedge clk);
        check_val("t4_pause_audio", {24'h0, audio_out}, 32'd0);
        for (int i = 0; i < 5; i++) tick(0);
        check_val("t4_pause_audio2", {24'h0, audio_out}, 32'd0);
        check_val("t4_undr_paused", undr_cnt, 0);
        play = 1'b1;
        for (int i = 0; i < 6; i++) tick(i == 5);
        check_val("t4_done", done_cnt, 1);
        check_val("t4_undr", undr_cnt, 0);
        check_val("t4_left", exp_q.size(), 0);

        // 5: slow flash causes underruns, then silent playback
        do_reset();
        start_play(23'h10, 23'h11, 1'b1);
        flash_hold = 1'b1;
        push_word(23'h10, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(0);
        for (int i = 0; i < 3; i++) begin
            tick(0);
            check_val("t5_hold_audio", {24'h0, audio_out}, 32'h44);
        end
        check_val("t5_undr", undr_cnt, 3);
        flash_hold = 1'b0;
        repeat (4) @(negedge clk);
        silent = 1'b1;
        push_word(23'h11, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(i == 3);
        check_val("t5_done", done_cnt, 1);
        check_val("t5_left", exp_q.size(), 0);

        // 6: restart during an outstanding fetch, async reset, invalid range
        do_reset();
        start_play(23'h14, 23'h18, 1'b1);
        flash_hold = 1'b1;
        push_word(23'h14, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(0);
        wait_req(20);
        check_val("t6_req_addr", {9'h0, rd_addr}, 32'h15);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_val("t6_rst_req", {31'h0, rd_req}, 32'd0);
        check_val("t6_rst_addr", {9'h0, rd_addr}, 32'h14);
        check_val("t6_rst_busy", {31'h0, busy}, 32'd1);
        @(negedge clk);
        check_val("t6_rereq", {31'h0, rd_req}, 32'd1);
        check_val("t6_rereq_addr", {9'h0, rd_addr}, 32'h14);
        #2 reset_n = 1'b0;
        #1;
        check_val("t6_async_req", {31'h0, rd_req}, 32'd0);
        check_val("t6_async_addr", {9'h0, rd_addr}, 32'd0);
        check_val("t6_async_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        flash_hold = 1'b0;
        start_play(23'h30, 23'h2F, 1'b1);
        check_val("t6_bad_busy", {31'h0, busy}, 32'd0);
        check_val("t6_bad_req", {31'h0, rd_req}, 32'd0);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        repeat (2) @(negedge clk);
        check_val("t6_bad_rst_busy", {31'h0, busy}, 32'd0);
        check_val("t6_bad_rst_req", {31'h0, rd_req}, 32'd0);
        check_val("t6_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
